delay_arbiter: RTL and testbench

- Shares one external `delay` timer between NREQ requesters.
- Grants the timer to one requester at a time in round-robin order, clears and starts it, and waits for its overflow flag.
- Returns a one-cycle done pulse to the granted requester.
- Sits between the game/control FSMs and the single delay timer instance.

---
 rtl/delay_arbiter_pkg.sv | 14 +
 rtl/delay_arbiter_rr_pick.sv | 30 +++
 rtl/delay_arbiter.sv | 161 ++++++++++++++++
 tb/tb_delay_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_arbiter_pkg.sv
// Shared definitions for delay_arbiter: FSM state encoding and default parameters.
package delay_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam int DEF_NREQ        = 4;
    localparam int DEF_WDOG_CYCLES = 1023;

endpackage

// File: rtl/delay_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester above 'last', wrapping around.
module rr_pick
    import delay_arbiter_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [LW-1:0]   last_i,
    output logic [NREQ-1:0] pick_o,
    output logic            valid_o
);

    logic [LW-1:0] pos;

    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        pos     = '0;
        // Offsets 1..NREQ put the previous owner last in the search order.
        for (int i = 1; i <= NREQ; i++) begin
            pos = LW'((int'(last_i) + i) % NREQ);
            if (!valid_o && req_i[pos]) begin
                pick_o[pos] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one delay timer among NREQ requesters.
// Optional RUN watchdog with sticky err output: define DELAY_ARBITER_WDOG_EN.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic            clock,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            timer_of,
    output logic            timer_start,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic            err
);

    localparam int LW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("delay_arbiter: NREQ must be 2..8 and WDOG_CYCLES at least 1");
    end

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            timer_start_q, timer_start_d;
    logic            busy_q, busy_d;
    logic [LW-1:0]   last_q, last_d;
    logic [LW-1:0]   owner_idx;
    logic            owner_req;
    logic [NREQ-1:0] pick;
    logic            pick_valid;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) owner_idx = LW'(i);
        end
    end

    assign owner_req = |(req & grant_q);

`ifdef DELAY_ARBITER_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
    logic          wdog_expired;

    assign wdog_expired = (wdog_q == WW'(WDOG_CYCLES));
    assign err          = err_q;
`else
    assign err = 1'b0;
`endif

    // NOTE: every signal written below gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        done_d        = '0;
        timer_start_d = timer_start_q;
        last_d        = last_q;
`ifdef DELAY_ARBITER_WDOG_EN
        wdog_d        = wdog_q;
        err_d         = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d       = pick;
                    state_d       = ARM;
                    timer_start_d = 1'b0;
                end
            end
            ARM: begin
                state_d       = RUN;
                timer_start_d = 1'b1;
`ifdef DELAY_ARBITER_WDOG_EN
                wdog_d        = '0;
`endif
            end
            RUN: begin
                // Overflow outranks both a dropped request and watchdog expiry.
                if (timer_of) begin
                    state_d       = FIN;
                    done_d        = grant_q;
                    grant_d       = '0;
                    timer_start_d = 1'b0;
                    last_d        = owner_idx;
                end else if (!owner_req) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    timer_start_d = 1'b0;
                    last_d        = owner_idx;
`ifdef DELAY_ARBITER_WDOG_EN
                end else if (wdog_expired) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    timer_start_d = 1'b0;
                    last_d        = owner_idx;
                    err_d         = 1'b1;
                end else begin
                    wdog_d        = wdog_q + WW'(1);
`endif
                end
            end
            FIN: begin
                state_d       = IDLE;
                timer_start_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            done_q        <= '0;
            timer_start_q <= 1'b0;
            busy_q        <= 1'b0;
            last_q        <= LW'(NREQ - 1);
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            timer_start_q <= timer_start_d;
            busy_q        <= busy_d;
            last_q        <= last_d;
        end
    end

`ifdef DELAY_ARBITER_WDOG_EN
    always_ff @(posedge clock) begin
        if (!rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
`endif

    assign timer_start = timer_start_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboard bench for delay_arbiter with a behavioural delay timer model.
module tb_delay_arbiter;

    localparam int NREQ = 4;
`ifdef DELAY_ARBITER_WDOG_EN
    localparam int WDOG = 30;
    localparam int T    = 20;
`else
    localparam int WDOG = 1023;
    localparam int T    = 50;
`endif

    logic            clock = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            timer_of;
    logic            timer_start;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            busy;
    logic            err;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   tie_of = 1'b0;

    typedef struct {
        logic [NREQ-1:0] vec;
        int              at;
    } exp_t;
    exp_t sb[$];

    delay_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
        .clock       (clock),
        .rst         (rst),
        .req         (req),
        .timer_of    (timer_of),
        .timer_start (timer_start),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .err         (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Timer: clears while start is low, counts while high, flags overflow one edge after count==T.
    int   tcount = 0;
    logic of_q = 1'b0;
    always @(posedge clock) begin
        if (!timer_start) begin
            tcount <= 0;
            of_q   <= 1'b0;
        end else begin
            tcount <= tcount + 1;
            of_q   <= (tcount == T);
        end
    end
    assign timer_of = of_q & ~tie_of;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [NREQ-1:0] prev_grant = '0;
    always @(negedge clock) begin
        exp_t e;
        check("grant_onehot0", 32'($onehot0(grant)), 1);
        check("done_subset", 32'(done & ~prev_grant), 0);
        if (done != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 0);
            end else begin
                e = sb.pop_front();
                check("done_vec", 32'(done), 32'(e.vec));
                check("done_cycle", cyc, e.at);
            end
        end
        prev_grant = grant;
    end

    task automatic wait_done(output logic [NREQ-1:0] v);
        int n = 0;
        while (done == '0 && n < 4 * T + 40) begin
            step();
            n++;
        end
        check("done_timeout", 32'(done != '0), 1);
        v = done;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == '0 && n < 20) begin
            step();
            n++;
        end
        check("grant_timeout", 32'(grant != '0), 1);
    endtask

    // One complete transaction starting from IDLE; done expected T+4 edges after drive.
    task automatic run_one(input logic [NREQ-1:0] req_vec, input logic [NREQ-1:0] exp_grant);
        logic [NREQ-1:0] v;
        sb.push_back('{exp_grant, cyc + T + 4});
        req = req_vec;
        step();
        check("grant", 32'(grant), 32'(exp_grant));
        check("busy_arm", 32'(busy), 1);
        check("ts_arm", 32'(timer_start), 0);
        step();
        check("ts_run", 32'(timer_start), 1);
        wait_done(v);
        req = '0;
        step();
        check("busy_idle", 32'(busy), 0);
        check("done_clear", 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] one;
        int n0;

        rst = 1'b0;
        req = '1;
        repeat (3) step();
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ts", 32'(timer_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);

        // Round robin with all requesters held; each drops after its done.
        n0 = cyc;
        rst = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            one = NREQ'(1) << k;
            sb.push_back('{one, n0 + T + 4 + k * (T + 5)});
        end
        for (int k = 0; k < NREQ; k++) begin
            one = NREQ'(1) << k;
            wait_grant();
            check("rr_grant", 32'(grant), 32'(one));
            wait_done(v);
            req = req & ~v;
        end
        step();
        run_one('1, 4'b0001);

        run_one(4'b0100, 4'b0100);

        // Abort 10 edges into RUN; pointer must move past requester 1.
        req = 4'b0010;
        step();
        check("abort_grant_arm", 32'(grant), 32'(4'b0010));
        step();
        check("abort_ts_run", 32'(timer_start), 1);
        repeat (10) step();
        req = '0;
        step();
        check("abort_grant", 32'(grant), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_ts", 32'(timer_start), 0);
        repeat (3) step();
        run_one(4'b0011, 4'b0001);

        // Reset in the middle of RUN, then a clean restart with full delay.
        req = 4'b0001;
        step();
        step();
        repeat (20) step();
        rst = 1'b0;
        req = '0;
        step();
        check("midrst_grant", 32'(grant), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_ts", 32'(timer_start), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_err", 32'(err), 0);
        rst = 1'b1;
        step();
        run_one(4'b1000, 4'b1000);

`ifdef DELAY_ARBITER_WDOG_EN
        tie_of = 1'b1;
        n0 = cyc;
        req = 4'b0001;
        step();
        step();
        begin
            int n = 0;
            while (!err && n < WDOG + 20) begin
                step();
                n++;
            end
        end
        check("wdog_err", 32'(err), 1);
        check("wdog_cycle", cyc, n0 + 3 + WDOG);
        check("wdog_grant", 32'(grant), 0);
        check("wdog_ts", 32'(timer_start), 0);
        req = '0;
        repeat (5) step();
        check("wdog_sticky", 32'(err), 1);
        rst = 1'b0;
        step();
        check("wdog_rst_err", 32'(err), 0);
        rst = 1'b1;
        tie_of = 1'b0;
`endif

        repeat (3) step();
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
